// File: rtl/crc32_stream_append_if.sv
// Byte-stream handshake bundle: data/valid/last forward, ready back.
// One instance per side of a stream stage.
interface crc32_stream_append_if;
    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       ready;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );
endinterface

// File: rtl/crc32_stream_append.sv
// CRC-32/MPEG-2 over a byte stream, one registered output stage.
// Optionally appends the 4 CRC bytes (MSB first) after each frame.
module crc32_stream_append #(
    parameter logic [31:0] CRC_INIT = 32'hFFFF_FFFF,
    parameter int unsigned APPEND   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    crc32_stream_append_if.slave  s,
    crc32_stream_append_if.master m,
    output logic [31:0]           crc_o,
    output logic                  crc_done
);

    localparam logic [31:0] POLY = 32'h04C1_1DB7;
    localparam bit          APP  = (APPEND != 0);

    typedef enum logic [0:0] {
        ST_PASS,
        ST_APPEND
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] crc_q;
    logic [1:0]  cnt;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        last_q;

    logic        s_ready;
    logic        s_fire;
    logic        m_fire;
    logic        out_free;
    logic        load_crc;
    logic [7:0]  crc_sel;
    logic [31:0] crc_step;

    // One byte through the MSB-first shift register, bit 7 first.
    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c ^ {d, 24'h0};
        for (int i = 0; i < 8; i++) begin
            r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
        end
        return r;
    endfunction

    assign crc_step = crc_byte(crc_q, s.data);
    assign m_fire   = valid_q && m.ready;
    assign out_free = !valid_q || m.ready;
    assign s.ready  = s_ready;
    assign m.data   = data_q;
    assign m.valid  = valid_q;
    assign m.last   = last_q;

    // Pick the CRC byte to emit next, most significant first.
    always_comb begin
        crc_sel = crc_o[31:24];
        unique case (cnt)
            2'd0: crc_sel = crc_o[31:24];
            2'd1: crc_sel = crc_o[23:16];
            2'd2: crc_sel = crc_o[15:8];
            2'd3: crc_sel = crc_o[7:0];
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_PASS;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake decisions.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        s_fire     = 1'b0;
        load_crc   = 1'b0;
        unique case (state)
            ST_PASS: begin
                s_ready = out_free;
                s_fire  = s.valid && out_free;
                if (s_fire && s.last && APP) begin
                    state_next = ST_APPEND;
                end
            end
            ST_APPEND: begin
                // Only the 4th CRC byte carries last in this mode.
                if (m_fire && last_q) begin
                    state_next = ST_PASS;
                end else if (out_free) begin
                    load_crc = 1'b1;
                end
            end
            default: begin
                state_next = ST_PASS;
            end
        endcase
    end

    // Output stage, running CRC, append counter and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q    <= CRC_INIT;
            cnt      <= 2'd0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            crc_o    <= 32'h0;
            crc_done <= 1'b0;
        end else begin
            crc_done <= 1'b0;
            if (s_fire) begin
                data_q  <= s.data;
                valid_q <= 1'b1;
                last_q  <= APP ? 1'b0 : s.last;
            end else if (load_crc) begin
                data_q  <= crc_sel;
                valid_q <= 1'b1;
                last_q  <= (cnt == 2'd3);
                cnt     <= 2'(cnt + 2'd1);
            end else if (m_fire) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
            if (s_fire) begin
                if (s.last) begin
                    crc_o    <= crc_step;
                    crc_done <= 1'b1;
                    crc_q    <= CRC_INIT;
                end else begin
                    crc_q <= crc_step;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc32_stream_append.sv
// Bench for crc32_stream_append: APPEND=1 and APPEND=0 instances,
// fixed vectors, corner sequences and random frames vs a table CRC model.
module tb_crc32_stream_append;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] crc1, crc0;
    logic        done1, done0;

    int tests = 0;
    int fails = 0;
    int out1  = 0;
    int cyc   = 0;
    bit rnd1  = 0;
    bit rnd0  = 0;

    crc32_stream_append_if s1();
    crc32_stream_append_if m1();
    crc32_stream_append_if s0();
    crc32_stream_append_if m0();

    crc32_stream_append #(.CRC_INIT(32'hFFFF_FFFF), .APPEND(1)) dut (
        .clk(clk), .rst(rst), .s(s1), .m(m1),
        .crc_o(crc1), .crc_done(done1)
    );

    crc32_stream_append #(.CRC_INIT(32'hFFFF_FFFF), .APPEND(0)) dut0 (
        .clk(clk), .rst(rst), .s(s0), .m(m0),
        .crc_o(crc0), .crc_done(done0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] ctab [256];
    logic [8:0]  txq [$];
    logic [8:0]  exp1 [$];
    logic [8:0]  exp0 [$];
    logic [31:0] crcq1 [$];
    logic [31:0] crcq0 [$];
    logic [7:0]  chk [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                             8'h36, 8'h37, 8'h38, 8'h39};

    typedef struct {
        int          len;
        logic [7:0]  b [16];
        bit          rnd;
        bit          gaps;
        logic [31:0] crc;
    } vec_t;

    vec_t vt [4];

    function automatic void build_tab();
        logic [31:0] r;
        for (int n = 0; n < 256; n++) begin
            r = 32'(n) << 24;
            for (int k = 0; k < 8; k++) begin
                r = r[31] ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
            end
            ctab[n] = r;
        end
    endfunction

    function automatic logic [31:0] ref_crc(input logic [7:0] b [$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) c = (c << 8) ^ ctab[c[31:24] ^ b[i]];
        return c;
    endfunction

    function automatic void push_frame(input bit which,
                                       input logic [7:0] b [$],
                                       input logic [31:0] c);
        int n;
        n = b.size();
        for (int i = 0; i < n; i++) begin
            txq.push_back({(i == n - 1), b[i]});
            if (which) exp1.push_back({1'b0, b[i]});
            else exp0.push_back({(i == n - 1), b[i]});
        end
        if (which) begin
            for (int k = 0; k < 4; k++)
                exp1.push_back({(k == 3), c[31 - 8 * k -: 8]});
            crcq1.push_back(c);
        end else begin
            crcq0.push_back(c);
        end
    endfunction

    task automatic drive(input bit which, input logic v,
                         input logic [7:0] d, input logic l);
        if (which) begin
            s1.valid = v; s1.data = d; s1.last = l;
        end else begin
            s0.valid = v; s0.data = d; s0.last = l;
        end
    endtask

    task automatic send(input bit which, input bit gaps);
        logic [8:0] it;
        int budget;
        bit f;
        while (txq.size() > 0) begin
            it = txq.pop_front();
            if (gaps && $urandom_range(0, 3) == 0) begin
                drive(which, 1'b0, 8'($urandom), 1'($urandom));
                @(posedge clk); #1;
            end
            drive(which, 1'b1, it[7:0], it[8]);
            f = 0;
            budget = 0;
            while (!f && budget < 500) begin
                @(negedge clk);
                f = which ? s1.ready : s0.ready;
                @(posedge clk); #1;
                budget++;
            end
            if (!f) begin
                tests++; fails++;
                $display("FAIL send_timeout dut%0d: s_ready got 0, need 1", which);
            end
        end
        drive(which, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp1.size() || exp0.size() || crcq1.size() ||
                crcq0.size()) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (exp1.size() || exp0.size() || crcq1.size() || crcq0.size()) begin
            fails++;
            $display("FAIL drain_%s: pending got %0d/%0d/%0d/%0d, need 0",
                     tag, exp1.size(), exp0.size(), crcq1.size(), crcq0.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, need %h", tag, got, want);
        end
    endtask

    // Random downstream backpressure, changed just after each edge.
    initial forever begin
        @(posedge clk); #1;
        m1.ready = rnd1 ? 1'($urandom_range(0, 1)) : 1'b1;
        m0.ready = rnd0 ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    bit         held1, held0;
    logic [8:0] hd1, hd0;

    // Monitor for the APPEND=1 instance.
    always @(negedge clk) begin
        if (rst) begin
            held1 = 0;
        end else begin
            if (held1 && m1.valid)
                check("hold1", {23'h0, m1.last, m1.data}, {23'h0, hd1});
            held1 = m1.valid && !m1.ready;
            hd1 = {m1.last, m1.data};
            if (m1.valid && !m1.ready)
                check("stall_ready1", {31'h0, s1.ready}, 32'h0);
            if (m1.valid && m1.ready) begin
                out1++;
                if (exp1.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL out1_extra: got %h, need none",
                             {m1.last, m1.data});
                end else begin
                    check("out1", {23'h0, m1.last, m1.data},
                          {23'h0, exp1.pop_front()});
                end
            end
            if (done1) begin
                if (crcq1.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL done1_extra: got pulse crc %h, need none", crc1);
                end else begin
                    check("crc1", crc1, crcq1.pop_front());
                end
            end
        end
    end

    // Monitor for the APPEND=0 instance.
    always @(negedge clk) begin
        if (rst) begin
            held0 = 0;
        end else begin
            if (held0 && m0.valid)
                check("hold0", {23'h0, m0.last, m0.data}, {23'h0, hd0});
            held0 = m0.valid && !m0.ready;
            hd0 = {m0.last, m0.data};
            check("ready0", {31'h0, s0.ready},
                  {31'h0, (!m0.valid || m0.ready)});
            if (m0.valid && m0.ready) begin
                if (exp0.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL out0_extra: got %h, need none",
                             {m0.last, m0.data});
                end else begin
                    check("out0", {23'h0, m0.last, m0.data},
                          {23'h0, exp0.pop_front()});
                end
            end
            if (done0) begin
                if (crcq0.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL done0_extra: got pulse crc %h, need none", crc0);
                end else begin
                    check("crc0", crc0, crcq0.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, need $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q [$];
        int b, n, c0;
        build_tab();
        rst = 1'b1;
        m1.ready = 1'b1;
        m0.ready = 1'b1;
        drive(1, 1'b0, 8'h00, 1'b0);
        drive(0, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid1", {31'h0, m1.valid}, 32'h0);
        check("rst_last1", {31'h0, m1.last}, 32'h0);
        check("rst_data1", {24'h0, m1.data}, 32'h0);
        check("rst_crc1", crc1, 32'h0);
        check("rst_done1", {31'h0, done1}, 32'h0);
        check("rst_ready1", {31'h0, s1.ready}, 32'h1);
        check("rst_ready0", {31'h0, s0.ready}, 32'h1);
        @(posedge clk); #1;

        // Fixed frames on the APPEND=1 instance.
        for (int i = 0; i < 4; i++) begin
            vt[i].rnd = 0; vt[i].gaps = 0; vt[i].len = 9;
            for (int k = 0; k < 16; k++) vt[i].b[k] = 8'h00;
        end
        for (int k = 0; k < 9; k++) begin
            vt[0].b[k] = chk[k];
            vt[1].b[k] = chk[k];
            vt[3].b[k] = chk[k];
        end
        vt[0].crc = 32'h0376_E6E7;
        vt[1].len = 13;
        vt[1].b[9] = 8'h03; vt[1].b[10] = 8'h76;
        vt[1].b[11] = 8'hE6; vt[1].b[12] = 8'hE7;
        vt[1].crc = 32'h0;
        vt[2].len = 1;
        vt[2].b[0] = 8'hA5;
        q = {8'hA5};
        vt[2].crc = ref_crc(q);
        vt[3].rnd = 1; vt[3].gaps = 1;
        vt[3].crc = 32'h0376_E6E7;

        for (int i = 0; i < 4; i++) begin
            q.delete();
            for (int k = 0; k < vt[i].len; k++) q.push_back(vt[i].b[k]);
            rnd1 = vt[i].rnd;
            push_frame(1, q, vt[i].crc);
            send(1, vt[i].gaps);
            wait_drain("vec");
            rnd1 = 0;
            check("vec_crc", crc1, vt[i].crc);
        end

        // Back-to-back frames, full throughput.
        q.delete();
        foreach (chk[k]) q.push_back(chk[k]);
        push_frame(1, q, 32'h0376_E6E7);
        push_frame(1, q, 32'h0376_E6E7);
        c0 = cyc;
        send(1, 0);
        check("b2b_cycles1", 32'(cyc - c0), 32'd23);
        wait_drain("b2b1");

        // Reset during the CRC append.
        b = out1;
        push_frame(1, q, 32'h0376_E6E7);
        send(1, 0);
        n = 0;
        while (out1 < b + 11 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("pre_rst_count", 32'(out1 - b), 32'd11);
        rst = 1'b1;
        exp1.delete();
        @(posedge clk); #1;
        check("mid_rst_valid", {31'h0, m1.valid}, 32'h0);
        check("mid_rst_last", {31'h0, m1.last}, 32'h0);
        check("mid_rst_ready", {31'h0, s1.ready}, 32'h1);
        rst = 1'b0;
        push_frame(1, q, 32'h0376_E6E7);
        send(1, 0);
        wait_drain("post_rst");
        check("post_rst_crc", crc1, 32'h0376_E6E7);

        // Pass-through instance.
        push_frame(0, q, 32'h0376_E6E7);
        send(0, 0);
        wait_drain("pass0");
        check("pass0_crc", crc0, 32'h0376_E6E7);
        push_frame(0, q, 32'h0376_E6E7);
        push_frame(0, q, 32'h0376_E6E7);
        c0 = cyc;
        send(0, 0);
        check("b2b_cycles0", 32'(cyc - c0), 32'd18);
        wait_drain("b2b0");

        // Random frames on both instances.
        for (int i = 0; i < 24; i++) begin
            bit w;
            logic [31:0] c;
            w = (i % 2 == 0);
            q.delete();
            n = $urandom_range(1, 16);
            for (int k = 0; k < n; k++) q.push_back(8'($urandom));
            c = ref_crc(q);
            rnd1 = w;
            rnd0 = !w;
            push_frame(w, q, c);
            send(w, 1);
            wait_drain("rand");
            rnd1 = 0;
            rnd0 = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/crc32_stream_append.md
CRC32_STREAM_APPEND -- requirements
Module: crc32_stream_append

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter CRC_INIT, default 32'hFFFFFFFF, SHALL be the CRC register start value for every frame.
REQ-003 Parameter APPEND, default 1, SHALL enable appending 4 CRC bytes; with APPEND=0 the block SHALL only pass data through and report the CRC.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 s_data  in  8  input byte; s_valid in 1 byte valid; s_last in 1 final byte of frame; s_ready out 1 block accepts byte.
REQ-007 m_data  out  8  output byte; m_valid out 1; m_last out 1 final byte of output frame; m_ready in 1 downstream accepts.
REQ-008 crc_o  out  32  final CRC of the last completed frame; crc_done out 1 one-cycle pulse when crc_o updates.

Function
REQ-009 CRC SHALL be polynomial 0x04C11DB7, left-shifting, non-reflected, no final XOR; each byte enters as crc_next = F(crc ^ {byte,24'h0}), bit 7 first (CRC-32/MPEG-2, check "123456789" = 0x0376E6E7).
REQ-010 A transfer on either side SHALL occur only on a cycle with valid && ready high.
REQ-011 Output SHALL be a single registered stage: an accepted s_data byte appears on m_data with m_valid the following cycle (latency 1).
REQ-012 In state PASS, s_ready SHALL equal (!m_valid || m_ready), allowing one byte per cycle at full throughput.
REQ-013 Each accepted input byte SHALL update the running CRC register in the same clock edge.
REQ-014 On acceptance of a byte with s_last=1: crc_o SHALL load the final CRC and crc_done SHALL pulse on the next cycle; with APPEND=1 the state SHALL go to APPEND, with APPEND=0 it SHALL stay in PASS.
REQ-015 With APPEND=1, the s_last byte SHALL be output with m_last=0; with APPEND=0, m_last SHALL equal the accepted s_last.
REQ-016 In APPEND, s_ready SHALL be 0; the block SHALL emit crc_o[31:24], [23:16], [15:8], [7:0] in order, tracked by a 2-bit counter advancing only on output handshakes.
REQ-017 The fourth CRC byte SHALL carry m_last=1; on its handshake the state SHALL return to PASS and s_ready SHALL follow REQ-012 from the next cycle.
REQ-018 The running CRC register SHALL reload CRC_INIT on the edge that accepts s_last, so back-to-back frames need no idle cycle.
REQ-019 m_data/m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-020 A single-byte frame (s_valid and s_last on the first byte) SHALL be legal and produce 1 data byte plus 4 CRC bytes.
REQ-021 s_data/s_last SHALL be ignored on cycles without an input handshake.

Reset
REQ-022 Reset SHALL force state PASS, CRC register = CRC_INIT, counter 0, m_valid=0, m_last=0, m_data=0, crc_o=0, crc_done=0.
REQ-023 Reset SHALL take priority over all handshakes in the same cycle; a frame in progress, including a partial CRC append, SHALL be discarded.
REQ-024 s_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-025 "123456789" (0x31..0x39), m_ready=1 -> output 31..39, 03 76 E6 E7, m_last only on E7, crc_o=0x0376E6E7, one crc_done pulse.
REQ-026 Frame 31..39 followed by 03 76 E6 E7 as one input frame -> crc_o=0x00000000.
REQ-027 Two "123456789" frames back-to-back with no gap -> both yield 0x0376E6E7 and no byte is lost or duplicated.
REQ-028 Random m_ready toggling during data and APPEND -> identical byte sequence to REQ-025, with m_data held stable while stalled.
REQ-029 rst asserted after the second CRC byte -> next cycle m_valid=0, state PASS, and a following "123456789" frame yields 0x0376E6E7.
REQ-030 APPEND=0, "123456789" -> 9 bytes out, m_last on 0x39, crc_o=0x0376E6E7.
